quarter_wave_osc: RTL
=====================

# quarter_wave_osc

Parametrised, time-multiplexed multi-channel oscillator that generates one bipolar sample per channel on every sweep request. Each channel has its own phase accumulator and tuning increment, with quarter-wave phase folding into an external synchronous sine ROM. It sits between the sample-rate tick generator and the mixer, and replaces the single-channel fixed-width quarter-wave sine stage.

## Interface
- `NCH`, 4, number of channels (≥2)
- `ACC_W`, 24, phase accumulator width
- `LUT_AW`, 14, quarter-wave ROM address width; phase width is `PW = LUT_AW+2`, taken from `acc[ACC_W-1 -: PW]` (requires `ACC_W ≥ PW`)
- `OUT_W`, 16, signed sample width; `MAX = 2^(OUT_W-1)-1`
- `CW` (localparam) = `$clog2(NCH)`

Ports:
- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `i_start` in 1: sweep request strobe
- `i_wr_en` in 1: channel config write
- `i_wr_ch` in CW: channel written
- `i_wr_inc` in ACC_W: new increment
- `i_wr_mode` in 2: waveform mode (see Configuration)
- `i_wr_clr` in 1: with `i_wr_en`, zero that channel's accumulator
- `o_lut_addr` out LUT_AW: ROM address, registered
- `i_lut_data` in OUT_W: ROM data, valid 1 cycle after `o_lut_addr`; range 0..MAX
- `o_valid` out 1: sample valid, one-cycle per channel
- `o_ch` out CW: channel of `o_val`
- `o_val` out OUT_W signed: sample
- `o_busy` out 1: sweep FSM in RUN
- `o_overrun` out 1: one-cycle pulse, start dropped

## Operation
- Reset: all acc, inc, and mode cleared to 0; FSM in IDLE; all outputs 0.
- FSM IDLE: `i_start` high → RUN, channel counter `c=0`. RUN: `c` increments each cycle; after `c=NCH-1` → IDLE.
- `i_start` while RUN: ignored, `o_overrun` pulses the next cycle.
- Stage S1 (channel `c`): `p ← acc[c][ACC_W-1 -: PW]`; `acc[c] ← acc[c]+inc[c]` mod 2^ACC_W. Mode and channel id travel with `p`.
- Stage S2 fold: `neg = p[PW-1]`; `o_lut_addr ← p[PW-2] ? ~p[LUT_AW-1:0] : p[LUT_AW-1:0]`.
- Stage S3: ROM returns data. `o_val ← neg ? -i_lut_data : i_lut_data`; `o_valid ← 1`; `o_ch ← c`.
- Write port, any time:
  - `inc`/`mode` are updated at the edge.
  - If S1 reads the same channel in that cycle, S1 uses the old inc and mode.
  - `i_wr_clr` forces `acc ← 0` and overrides the S1 accumulate on that channel.
- Pipeline drains fully after the FSM returns to IDLE.
- Asynchronous reset mid-sweep aborts the sweep; no further `o_valid`.

## Timing
- `i_start` sampled at edge E0 → `o_valid` high after edge E(4+k) for channel k, k=0..NCH-1, on consecutive cycles in ascending channel order.
- `o_busy` high after edges E0..E(NCH-1), low after E(NCH).
- Earliest accepted restart: `i_start` sampled at E(NCH). Back-to-back sweeps produce a gapless `o_valid` stream.
- `o_lut_addr` for channel k is valid after E(2+k); `i_lut_data` is sampled at E(4+k).
- `o_val` and `o_ch` hold their last value when `o_valid` is low.

## Configuration
- `QWO_MODES_EN` defined: per-channel 2-bit mode register, applied in S3:
  - 00 sine.
  - 01 square: `neg ? -MAX : MAX`.
  - 10 saw: top OUT_W bits of phase with MSB inverted, i.e. −2^(OUT_W-1) at p=0, rising.
  - 11 mute: 0, with `o_valid` still asserted.
  - Latency is identical in every mode.
- Undefined: no mode registers; `i_wr_mode` ignored; every channel outputs sine.

## Test plan
Defaults; ROM model = `round(32767·sin(π/2·a/16384))`.
- Reset: assert `rst_n`=0 mid-sweep → all outputs 0 immediately; no `o_valid` after release without `i_start`.
- ch0 inc=0x400000, four sweeps → ch0 `o_lut_addr` 0x0000, 0x3FFF, 0x0000, 0x3FFF; `o_val` 0, 32767, 0, −32767.
- Single start at E0, all inc=0 → `o_valid` after E4..E7, `o_ch` 0,1,2,3, all `o_val`=0; `o_busy` high after E0..E3.
- `i_start` held high 6 cycles → one sweep accepted at E0, `o_overrun` pulse per dropped cycle, restart at E4, 8 valid samples total.
- Write ch1 inc=0x100000 with clr in the same cycle that S1 processes ch1 (acc=0x200000) → that sample uses phase 0x2000; ch1 acc=0; next sweep phase 0x0000, following sweep 0x1000.
- With `QWO_MODES_EN`, ch0 modes 01/10/11 at phase 0xC000 → −32767, 0x4000, 0.

Source files
------------

// File: rtl/quarter_wave_osc.sv
// Time-multiplexed multi-channel quarter-wave sine oscillator feeding an external sync ROM.
// Optional per-channel waveform modes (square/saw/mute) enabled by defining QWO_MODES_EN.
module quarter_wave_osc #(
  parameter int NCH    = 4,
  parameter int ACC_W  = 24,
  parameter int LUT_AW = 14,
  parameter int OUT_W  = 16,
  localparam int CW    = $clog2(NCH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_wr_en,
  input  logic [CW-1:0]           i_wr_ch,
  input  logic [ACC_W-1:0]        i_wr_inc,
  input  logic [1:0]              i_wr_mode,
  input  logic                    i_wr_clr,
  output logic [LUT_AW-1:0]       o_lut_addr,
  input  logic [OUT_W-1:0]        i_lut_data,
  output logic                    o_valid,
  output logic [CW-1:0]           o_ch,
  output logic signed [OUT_W-1:0] o_val,
  output logic                    o_busy,
  output logic                    o_overrun
);

  localparam int PW = LUT_AW + 2;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);
  localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    c_q, c_d;
  logic             ovr_d;
  logic             run;

  logic [ACC_W-1:0] acc [NCH];
  logic [ACC_W-1:0] inc [NCH];

  logic             v1, v2, v3;
  logic [CW-1:0]    ch1, ch2, ch3;
  logic [PW-1:0]    p1;
  logic             neg2, neg3;
  logic [OUT_W-1:0] samp;

`ifdef QWO_MODES_EN
  localparam int SW = (OUT_W < PW) ? OUT_W : PW;
  localparam logic [OUT_W-1:0] MSB = {1'b1, {(OUT_W-1){1'b0}}};
  logic [1:0]       mode [NCH];
  logic [1:0]       mode1, mode2, mode3;
  logic [SW-1:0]    saw2, saw3;
  logic [OUT_W-1:0] saw;
`else
  logic             unused_wr_mode;
  assign unused_wr_mode = ^i_wr_mode;
`endif

  assign run    = (state_q == RUN);
  assign o_busy = run;

  // A start on the last RUN cycle chains straight into the next sweep.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          c_d     = '0;
        end
      end
      RUN: begin
        if (c_q == LAST) begin
          c_d = '0;
          if (!i_start) state_d = IDLE;
        end else begin
          c_d   = c_q + 1'b1;
          ovr_d = i_start;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      c_q       <= '0;
      o_overrun <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      o_overrun <= ovr_d;
    end
  end

  // Write port comes after the S1 accumulate so a clear wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        inc[i] <= '0;
`ifdef QWO_MODES_EN
        mode[i] <= '0;
`endif
      end
    end else begin
      if (run) acc[c_q] <= acc[c_q] + inc[c_q];
      if (i_wr_en) begin
        inc[i_wr_ch] <= i_wr_inc;
`ifdef QWO_MODES_EN
        mode[i_wr_ch] <= i_wr_mode;
`endif
        if (i_wr_clr) acc[i_wr_ch] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      ch1 <= '0; ch2 <= '0; ch3 <= '0;
      p1 <= '0; neg2 <= 1'b0; neg3 <= 1'b0;
      o_lut_addr <= '0;
      o_valid    <= 1'b0;
      o_ch       <= '0;
      o_val      <= '0;
`ifdef QWO_MODES_EN
      mode1 <= '0; mode2 <= '0; mode3 <= '0;
      saw2 <= '0; saw3 <= '0;
`endif
    end else begin
      v1 <= run;
      if (run) begin
        p1  <= acc[c_q][ACC_W-1 -: PW];
        ch1 <= c_q;
`ifdef QWO_MODES_EN
        mode1 <= mode[c_q];
`endif
      end
      v2 <= v1;
      if (v1) begin
        neg2       <= p1[PW-1];
        o_lut_addr <= p1[PW-2] ? ~p1[LUT_AW-1:0] : p1[LUT_AW-1:0];
        ch2        <= ch1;
`ifdef QWO_MODES_EN
        mode2 <= mode1;
        saw2  <= p1[PW-1 -: SW];
`endif
      end
      v3 <= v2;
      if (v2) begin
        neg3 <= neg2;
        ch3  <= ch2;
`ifdef QWO_MODES_EN
        mode3 <= mode2;
        saw3  <= saw2;
`endif
      end
      o_valid <= v3;
      if (v3) begin
        o_ch  <= ch3;
        o_val <= samp;
      end
    end
  end

  always_comb begin
    samp = neg3 ? -i_lut_data : i_lut_data;
`ifdef QWO_MODES_EN
    saw = (OUT_W'(saw3) << (OUT_W - SW)) ^ MSB;
    case (mode3)
      2'b01:   samp = neg3 ? -MAXV : MAXV;
      2'b10:   samp = saw;
      2'b11:   samp = '0;
      default: ;
    endcase
`endif
  end

endmodule
